fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_ctrl_if.sv | 42 ++++
 rtl/fetch_resp_buf.sv | 44 ++++
 rtl/fetch_ctrl.sv | 116 +++++++++++
 tb/tb_fetch_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Byte stride between consecutive instruction words.
    localparam int unsigned INSTR_BYTES = 4;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_if
//  Description : Bundles the redirect input, the instruction-memory
//                request/response channel and the decode-side handshake.
//                master = fetch controller, slave = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int WordSize = 32
);
    logic                branch_taken;
    logic [WordSize-1:0] branch_addr;

    logic                imem_req_valid;
    logic [WordSize-1:0] imem_req_addr;
    logic                imem_req_ready;
    logic                imem_resp_valid;
    logic [WordSize-1:0] imem_resp_data;

    logic                if_valid;
    logic [WordSize-1:0] if_pc;
    logic [WordSize-1:0] if_instr;
    logic                if_ready;

    modport master (
        input  branch_taken, branch_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_ready,
        output imem_req_valid, imem_req_addr,
        output if_valid, if_pc, if_instr
    );

    modport slave (
        output branch_taken, branch_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_ready,
        input  imem_req_valid, imem_req_addr,
        input  if_valid, if_pc, if_instr
    );
endinterface : fetch_ctrl_if
`default_nettype wire

// File: rtl/fetch_resp_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_resp_buf
//  Description : One-entry buffer holding a fetched instruction and the PC
//                it was fetched from. Load wins over clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_resp_buf #(
    parameter int WordSize = 32
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                load_i,
    input  wire logic                clear_i,
    input  wire logic [WordSize-1:0] pc_i,
    input  wire logic [WordSize-1:0] instr_i,
    output logic                     valid_o,
    output logic [WordSize-1:0]      pc_o,
    output logic [WordSize-1:0]      instr_o
);
    logic                valid_q;
    logic [WordSize-1:0] pc_q;
    logic [WordSize-1:0] instr_q;

    // Capture a response on load; on clear only the valid bit drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
endmodule : fetch_resp_buf
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Single-outstanding instruction fetch controller with branch
//                redirect. A redirect that overtakes an in-flight request
//                marks its response as dropped so stale instructions never
//                reach decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                  WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = '0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_ctrl_if.master  bus
);
    fetch_state_e        state_q, state_d;
    logic [WordSize-1:0] pc_q, pc_d;
    logic                drop_q, drop_d;

    logic                w_buf_load;
    logic                w_buf_clear;
    logic [WordSize-1:0] w_target;
    logic [WordSize-1:0] w_pc_next;

    // Redirect targets are forced onto a word boundary.
    assign w_target  = {bus.branch_addr[WordSize-1:2], 2'b00};
    // Wraps naturally at 2^WordSize.
    assign w_pc_next = pc_q + WordSize'(INSTR_BYTES);

    // State, PC and drop flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= ResetVector;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic. pc_q holds the address of the outstanding request
    // through WAIT/HOLD; it only moves in WAIT on a redirect, which also
    // marks the response as dropped, so pc_q is a valid tag for the buffer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        w_buf_load  = 1'b0;
        w_buf_clear = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (bus.branch_taken) pc_d = w_target;
            end
            REQ: begin
                if (bus.branch_taken) pc_d = w_target;
                if (bus.imem_req_ready) begin
                    state_d = WAIT;
                    drop_d  = bus.branch_taken;
                end
            end
            WAIT: begin
                if (bus.imem_resp_valid) begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                    if (bus.branch_taken) begin
                        pc_d = w_target;
                    end else if (!drop_q) begin
                        w_buf_load = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (bus.branch_taken) begin
                    pc_d   = w_target;
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                // Redirect beats a simultaneous decode handshake.
                if (bus.branch_taken) begin
                    w_buf_clear = 1'b1;
                    pc_d        = w_target;
                    state_d     = REQ;
                end else if (bus.if_ready) begin
                    w_buf_clear = 1'b1;
                    pc_d        = w_pc_next;
                    state_d     = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.imem_req_addr  = pc_q;

    fetch_resp_buf #(
        .WordSize (WordSize)
    ) u_resp_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_buf_load),
        .clear_i (w_buf_clear),
        .pc_i    (pc_q),
        .instr_i (bus.imem_resp_data),
        .valid_o (bus.if_valid),
        .pc_o    (bus.if_pc),
        .instr_o (bus.if_instr)
    );
endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl with a latency-
//                configurable memory model and request/decode scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.WordSize(32)) bus ();

    fetch_ctrl #(
        .WordSize    (32),
        .ResetVector (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_req[$];
    item_t       exp_if[$];

    bit          mem_auto;
    int          mem_lat;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic item_t mk(input logic [31:0] pc);
        item_t it;
        it.pc    = pc;
        it.instr = mem_word(pc);
        return it;
    endfunction

    // One clock: score handshakes visible now, advance, then let memory respond.
    task automatic cycle();
        logic [31:0] ea;
        item_t       ei;
        if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
            checks++;
            if (exp_req.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got addr %h, required no request", bus.imem_req_addr);
            end else begin
                ea = exp_req.pop_front();
                if (bus.imem_req_addr !== ea) begin
                    errors++;
                    $display("FAIL req_addr: got %h, required %h", bus.imem_req_addr, ea);
                end
            end
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = bus.imem_req_addr;
        end
        if (bus.if_valid === 1'b1 && bus.if_ready === 1'b1 && bus.branch_taken !== 1'b1) begin
            checks++;
            if (exp_if.size() == 0) begin
                errors++;
                $display("FAIL if_unexpected: got pc %h instr %h, required no consume", bus.if_pc, bus.if_instr);
            end else begin
                ei = exp_if.pop_front();
                if (bus.if_pc !== ei.pc || bus.if_instr !== ei.instr) begin
                    errors++;
                    $display("FAIL if_item: got pc %h instr %h, required pc %h instr %h",
                             bus.if_pc, bus.if_instr, ei.pc, ei.instr);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (mem_auto) begin
            bus.imem_resp_valid = 1'b0;
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_word(mem_addr);
                    mem_busy            = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        bus.branch_taken    = 1'b0;
        bus.branch_addr     = '0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.if_ready        = 1'b0;
        mem_auto = 1'b1;
        mem_lat  = 1;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        exp_req.delete();
        exp_if.delete();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        int n = 0;
        while (exp_if.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        ok = (exp_if.size() == 0) && (exp_req.size() == 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: got req_valid %b if_valid %b, required 0 0", bus.imem_req_valid, bus.if_valid);
        end
        checks++;
        if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_if_regs: got pc %h instr %h, required 0 0", bus.if_pc, bus.if_instr);
        end
        cycle();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: got valid %b addr %h, required 1 00000000", bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_req.push_back(32'(i * 4));
            exp_if.push_back(mk(32'(i * 4)));
        end
        drain(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL seq_drain: got %0d items left, required 0", exp_if.size() + exp_req.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        cycle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
                errors++;
                $display("FAIL stall_hold: got valid %b addr %h, required 1 00000000", bus.imem_req_valid, bus.imem_req_addr);
            end
            cycle();
        end
        exp_req.push_back(32'h0);
        bus.imem_req_ready = 1'b1;
        cycle();
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_req: got req_valid %b, required 0", bus.imem_req_valid);
        end
        exp_if.push_back(mk(32'h0));
        bus.if_ready = 1'b1;
        drain(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_drain: got %0d items left, required 0", exp_if.size() + exp_req.size());
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        int n = 0;
        do_reset();
        mem_lat            = 3;
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        exp_req.push_back(32'h8);
        exp_req.push_back(32'h100);
        exp_if.push_back(mk(32'h0));
        exp_if.push_back(mk(32'h4));
        exp_if.push_back(mk(32'h100));
        while (exp_req.size() > 1 && n < 60) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_req.size() != 1) begin
            errors++;
            $display("FAIL rdw_reach_wait: got %0d requests pending, required 1", exp_req.size());
        end
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h100;
        cycle();
        bus.branch_taken = 1'b0;
        drain(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rdw_drain: got %0d items left, required 0", exp_if.size() + exp_req.size());
        end
    endtask

    task automatic test_redirect_on_handshake();
        bit ok;
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        cycle();
        exp_req.push_back(32'h0);
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h41;
        cycle();
        bus.branch_taken = 1'b0;
        exp_req.push_back(32'h40);
        exp_if.push_back(mk(32'h40));
        drain(30, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rdh_drain: got %0d items left, required 0", exp_if.size() + exp_req.size());
        end
    endtask

    task automatic test_hold_redirect();
        bit ok;
        int n = 0;
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        exp_if.push_back(mk(32'h0));
        drain(20, ok);
        bus.if_ready = 1'b0;
        while (bus.if_valid !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4 || bus.if_instr !== mem_word(32'h4)) begin
            errors++;
            $display("FAIL hold_present: got valid %b pc %h instr %h, required 1 00000004 %h",
                     bus.if_valid, bus.if_pc, bus.if_instr, mem_word(32'h4));
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4) begin
                errors++;
                $display("FAIL hold_stable: got valid %b pc %h, required 1 00000004", bus.if_valid, bus.if_pc);
            end
        end
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h203;
        bus.if_ready     = 1'b1;
        exp_req.push_back(32'h200);
        exp_if.push_back(mk(32'h200));
        cycle();
        bus.branch_taken = 1'b0;
        checks++;
        if (bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_discard: got if_valid %b, required 0", bus.if_valid);
        end
        drain(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_drain: got %0d items left, required 0", exp_if.size() + exp_req.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        bus.branch_taken   = 1'b1;
        bus.branch_addr    = 32'hFFFF_FFFC;
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0000_0000);
        exp_if.push_back(mk(32'hFFFF_FFFC));
        exp_if.push_back(mk(32'h0000_0000));
        cycle();
        bus.branch_taken = 1'b0;
        drain(30, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_drain: got %0d items left, required 0", exp_if.size() + exp_req.size());
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int n = 0;
        do_reset();
        mem_lat            = 3;
        bus.imem_req_ready = 1'b1;
        exp_req.push_back(32'h0);
        while (exp_req.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        do_reset();
        mem_auto            = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hBAD0_BAD0;
        cycle();
        checks++;
        if (bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: got if_valid %b, required 0", bus.if_valid);
        end
        cycle();
        checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL stray_req: got if_valid %b req_valid %b addr %h, required 0 1 00000000",
                     bus.if_valid, bus.imem_req_valid, bus.imem_req_addr);
        end
        bus.imem_resp_valid = 1'b0;
        mem_auto            = 1'b1;
        bus.imem_req_ready  = 1'b1;
        bus.if_ready        = 1'b1;
        exp_req.push_back(32'h0);
        exp_if.push_back(mk(32'h0));
        drain(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_wait_drain: got %0d items left, required 0", exp_if.size() + exp_req.size());
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_on_handshake();
        test_hold_redirect();
        test_wrap();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule : tb_fetch_ctrl
`default_nettype wire
